// File: rtl/instr_fetch_responder_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_responder_pkg
// Shared definitions for the instruction fetch responder:
//   - DEFAULT_DEPTH / DEFAULT_MEM_LAT : default response FIFO depth and
//     instruction-memory read latency.
//   - fetch_entry_t : one fetch result (pc, instruction word, misalign flag).
//   - is_misaligned : true when the low address bits are not word aligned.
// ---------------------------------------------------------------------------
package instr_fetch_responder_pkg;

    localparam int DEFAULT_DEPTH   = 4;
    localparam int DEFAULT_MEM_LAT = 2;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        err;
    } fetch_entry_t;

    function automatic logic is_misaligned(input logic [1:0] addr_lo);
        return addr_lo != 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_responder_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_responder_if
// Bundles the fetch request, flush, instruction-memory and response signals.
//   master : the surroundings (program counter, memory, consumer)
//   slave  : the fetch responder
// Signals:
//   req_valid/req_addr/req_ready       fetch request handshake
//   flush                              branch redirect
//   mem_rd_en/mem_addr/mem_rdata       instruction memory read port
//   rsp_valid/rsp_ready                response handshake
//   rsp_instr/rsp_pc/rsp_err           response payload
// ---------------------------------------------------------------------------
interface instr_fetch_responder_if;

    logic        req_valid;
    logic [63:0] req_addr;
    logic        req_ready;
    logic        flush;

    logic        mem_rd_en;
    logic [63:0] mem_addr;
    logic [31:0] mem_rdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [63:0] rsp_pc;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, flush, mem_rdata, rsp_ready,
        input  req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_instr, rsp_pc, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, flush, mem_rdata, rsp_ready,
        output req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_instr, rsp_pc, rsp_err
    );

endinterface

// File: rtl/instr_fetch_responder_fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Response FIFO holding completed fetch entries in acceptance order.
// Ports:
//   clk, rst   clock, synchronous active-high reset (control state only)
//   clear      discard all entries (has priority over push/pop)
//   push       write push_data at the tail
//   pop        drop the head entry (ignored when empty)
//   head       current head entry
//   empty      no entries held
//   count      number of entries held (0..DEPTH)
// ---------------------------------------------------------------------------
module fetch_fifo
    import instr_fetch_responder_pkg::*;
#(
    parameter int  DEPTH   = DEFAULT_DEPTH,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));
    assign do_pop = pop & ~empty;
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // The credit scheme upstream keeps a push from ever landing on a full FIFO.
            assert (!(push && full));
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is data only; stale contents are never visible because the
    // top gates the head with the empty flag.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/instr_fetch_responder.sv
// ---------------------------------------------------------------------------
// instr_fetch_responder
// Accepts instruction fetch requests, issues reads to a fixed-latency
// instruction memory, and returns responses in acceptance order through a
// response FIFO. Misaligned requests skip the memory read but still take a
// slot so ordering is preserved; they come back with err=1 and instr=0.
// A flush discards everything queued or in flight.
// Parameters:
//   DEPTH    response FIFO entries (also the outstanding-request limit)
//   MEM_LAT  memory read latency in cycles, 1..4
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   bus       instr_fetch_responder_if.slave (request, flush, memory, response)
// ---------------------------------------------------------------------------
module instr_fetch_responder
    import instr_fetch_responder_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int MEM_LAT = DEFAULT_MEM_LAT
) (
    input logic                     clk,
    input logic                     rst,
    instr_fetch_responder_if.slave  bus
);

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int CRED_W = $clog2(DEPTH + MEM_LAT) + 1;

    // Tracking shift register: stage i holds a request accepted i+1 cycles ago.
    logic [MEM_LAT-1:0] trk_vld;
    logic [MEM_LAT-1:0] trk_err;
    logic [63:0]        trk_pc [MEM_LAT];

    logic [CNT_W-1:0]   occupancy;
    logic [CRED_W-1:0]  inflight;
    logic [CRED_W-1:0]  credit;
    logic               can_accept;
    logic               accept;
    logic               misaligned;
    logic               fifo_empty;
    logic               pop;
    fetch_entry_t       push_entry;
    fetch_entry_t       head;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            inflight = inflight + CRED_W'(trk_vld[i]);
        end
    end

    // Credit counts every accepted-but-unconsumed fetch. It is taken before
    // any pop this cycle, so a slot freed by a pop is reusable next cycle.
    assign credit     = CRED_W'(occupancy) + inflight;
    assign can_accept = !rst && !bus.flush && (credit < CRED_W'(DEPTH));
    assign accept     = bus.req_valid && can_accept;
    assign misaligned = is_misaligned(bus.req_addr[1:0]);

    assign bus.req_ready = can_accept;
    assign bus.mem_rd_en = accept && !misaligned;
    assign bus.mem_addr  = bus.req_addr;

    // Stage boundary: request acceptance -> tracking register.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            trk_vld <= '0;
        end else begin
            trk_vld[0] <= accept;
            for (int i = 1; i < MEM_LAT; i++) begin
                trk_vld[i] <= trk_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        trk_pc[0]  <= bus.req_addr;
        trk_err[0] <= misaligned;
        for (int i = 1; i < MEM_LAT; i++) begin
            trk_pc[i]  <= trk_pc[i-1];
            trk_err[i] <= trk_err[i-1];
        end
    end

    // Stage boundary: last tracking stage lines up with mem_rdata -> FIFO.
    always_comb begin
        push_entry       = '0;
        push_entry.pc    = trk_pc[MEM_LAT-1];
        push_entry.err   = trk_err[MEM_LAT-1];
        push_entry.instr = trk_err[MEM_LAT-1] ? 32'h0 : bus.mem_rdata;
    end

    assign pop = bus.rsp_valid && bus.rsp_ready;

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (bus.flush),
        .push      (trk_vld[MEM_LAT-1]),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .count     (occupancy)
    );

    // Payload reads as zero whenever nothing is queued, which also keeps
    // uninitialised storage off the outputs after reset.
    assign bus.rsp_valid = !rst && !fifo_empty;
    assign bus.rsp_instr = fifo_empty ? 32'h0 : head.instr;
    assign bus.rsp_pc    = fifo_empty ? 64'h0 : head.pc;
    assign bus.rsp_err   = fifo_empty ? 1'b0  : head.err;

endmodule

// File: tb/tb_instr_fetch_responder.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_responder
// Directed scenarios plus a randomized run. A fixed-latency memory model
// answers reads, and a queue-based reference model tracks every accepted,
// not-yet-consumed fetch to predict req_ready, mem_rd_en and the responses.
// ---------------------------------------------------------------------------
module tb_instr_fetch_responder;
    import instr_fetch_responder_pkg::*;

    localparam int DEPTH   = 4;
    localparam int MEM_LAT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_fetch_responder_if bus ();

    instr_fetch_responder #(
        .DEPTH   (DEPTH),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Instruction memory content: 0x100 holds 32'h8B020020.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[63:32] ^ a[31:0] ^ 32'h8B02_0120;
    endfunction

    // Memory returns data exactly MEM_LAT cycles after the read strobe and
    // random junk in every other cycle.
    logic [31:0] mpipe [MEM_LAT];
    always @(posedge clk) begin
        mpipe[0] <= bus.mem_rd_en ? mem_word(bus.mem_addr) : $urandom;
        for (int i = 1; i < MEM_LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign bus.mem_rdata = mpipe[MEM_LAT-1];

    // Reference model: outstanding fetches in acceptance order, each with the
    // earliest cycle it may be presented.
    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        err;
        int          rdy;
    } exp_t;
    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        err;
    } got_t;

    exp_t q[$];
    got_t got[$];

    always @(negedge clk) begin : monitor
        logic exp_ready;
        logic exp_acc;
        logic exp_rd;
        logic exp_vld;
        exp_ready = !rst && !bus.flush && (q.size() < DEPTH);
        exp_acc   = bus.req_valid && exp_ready;
        exp_rd    = exp_acc && (bus.req_addr[1:0] == 2'b00);
        exp_vld   = !rst && (q.size() > 0) && (q.size() > 0 ? cyc >= q[0].rdy : 1'b0);

        n_tests++;
        if (bus.req_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL mon_req_ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, exp_ready);
        end
        n_tests++;
        if (bus.mem_rd_en !== exp_rd) begin
            n_fail++;
            $display("FAIL mon_mem_rd_en cyc=%0d got=%b exp=%b", cyc, bus.mem_rd_en, exp_rd);
        end
        if (exp_rd) begin
            n_tests++;
            if (bus.mem_addr !== bus.req_addr) begin
                n_fail++;
                $display("FAIL mon_mem_addr cyc=%0d got=%h exp=%h", cyc, bus.mem_addr, bus.req_addr);
            end
        end
        n_tests++;
        if (bus.rsp_valid !== exp_vld) begin
            n_fail++;
            $display("FAIL mon_rsp_valid cyc=%0d got=%b exp=%b", cyc, bus.rsp_valid, exp_vld);
        end
        if (exp_vld) begin
            n_tests++;
            if (bus.rsp_pc !== q[0].pc || bus.rsp_instr !== q[0].instr || bus.rsp_err !== q[0].err) begin
                n_fail++;
                $display("FAIL mon_rsp_data cyc=%0d got pc=%h instr=%h err=%b exp pc=%h instr=%h err=%b",
                         cyc, bus.rsp_pc, bus.rsp_instr, bus.rsp_err, q[0].pc, q[0].instr, q[0].err);
            end
        end

        if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1)
            got.push_back('{bus.rsp_pc, bus.rsp_instr, bus.rsp_err});

        // Advance the model to the state after the coming edge.
        if (rst) begin
            q.delete();
        end else begin
            if (exp_vld && bus.rsp_ready) void'(q.pop_front());
            if (bus.flush) begin
                q.delete();
            end else if (exp_acc) begin
                q.push_back('{bus.req_addr,
                              (bus.req_addr[1:0] != 2'b00) ? 32'h0 : mem_word(bus.req_addr),
                              (bus.req_addr[1:0] != 2'b00),
                              cyc + MEM_LAT + 1});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rand_addr(input bit aligned);
        logic [63:0] a;
        a = {$urandom, $urandom};
        if (aligned) a[1:0] = 2'b00;
        return a;
    endfunction

    task automatic wait_got(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (got.size() >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rsp_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 64'h40;
        bus.rsp_ready = 1'b1;
        bus.flush     = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_tests++;
            if ({bus.req_ready, bus.rsp_valid, bus.mem_rd_en} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_outputs got ready/valid/rd_en=%b%b%b exp=000",
                         bus.req_ready, bus.rsp_valid, bus.mem_rd_en);
            end
            tick();
        end
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.rsp_instr !== 32'h0 || bus.rsp_pc !== 64'h0 || bus.rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_payload got instr=%h pc=%h err=%b exp all zero",
                     bus.rsp_instr, bus.rsp_pc, bus.rsp_err);
        end
        n_tests++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready got=%b exp=1", bus.req_ready);
        end
        tick();
    endtask

    task automatic test_single();
        int start;
        bit ok;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 64'h100;
        @(negedge clk);
        start = cyc;
        n_tests++;
        if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 64'h100) begin
            n_fail++;
            $display("FAIL single_issue got rd_en=%b addr=%h exp rd_en=1 addr=100", bus.mem_rd_en, bus.mem_addr);
        end
        tick();
        bus.req_valid = 1'b0;
        wait_rsp_valid(20, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL single_timeout got no rsp_valid exp rsp_valid within 20 cycles");
        end else begin
            n_tests++;
            if (cyc - start != MEM_LAT + 1) begin
                n_fail++;
                $display("FAIL single_latency got=%0d exp=%0d", cyc - start, MEM_LAT + 1);
            end
            n_tests++;
            if (bus.rsp_pc !== 64'h100 || bus.rsp_instr !== 32'h8B020020 || bus.rsp_err !== 1'b0) begin
                n_fail++;
                $display("FAIL single_data got pc=%h instr=%h err=%b exp pc=100 instr=8b020020 err=0",
                         bus.rsp_pc, bus.rsp_instr, bus.rsp_err);
            end
        end
        repeat (2) tick();
    endtask

    task automatic test_back_pressure();
        int base;
        bit ok;
        base = got.size();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.req_addr = 64'(i * 4);
            @(negedge clk);
            n_tests++;
            if (bus.req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_accept_%0d got req_ready=%b exp=1", i, bus.req_ready);
            end
            tick();
        end
        bus.req_addr = 64'h10;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_full_%0d got req_ready=%b exp=0", i, bus.req_ready);
            end
            tick();
        end
        bus.rsp_ready = 1'b1;
        for (int a = 4; a < 6; a++) begin
            bus.req_addr = 64'(a * 4);
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (bus.req_ready === 1'b1) ok = 1'b1;
                tick();
                if (ok) break;
            end
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL bp_resume_%0d got no accept exp accept within 20 cycles", a);
            end
        end
        bus.req_valid = 1'b0;
        wait_got(base + 6, 40, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bp_drain got %0d responses exp 6", got.size() - base);
        end else begin
            for (int k = 0; k < 6; k++) begin
                n_tests++;
                if (got[base+k].pc !== 64'(k * 4) || got[base+k].instr !== mem_word(64'(k * 4))
                    || got[base+k].err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_order_%0d got pc=%h instr=%h exp pc=%h instr=%h",
                             k, got[base+k].pc, got[base+k].instr, 64'(k * 4), mem_word(64'(k * 4)));
                end
            end
        end
        repeat (2) tick();
    endtask

    task automatic test_flush();
        int base;
        int start;
        bit ok;
        base = got.size();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.req_addr = rand_addr(1'b1);
            tick();
        end
        bus.flush    = 1'b1;
        bus.req_addr = 64'h300;
        @(negedge clk);
        n_tests++;
        if (bus.req_ready !== 1'b0 || bus.mem_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_blocks_accept got ready=%b rd_en=%b exp 0 0", bus.req_ready, bus.mem_rd_en);
        end
        tick();
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_quiet_%0d got rsp_valid=%b exp=0", i, bus.rsp_valid);
            end
            tick();
        end
        n_tests++;
        if (got.size() != base) begin
            n_fail++;
            $display("FAIL flush_no_rsp got %0d responses exp 0", got.size() - base);
        end
        bus.req_valid = 1'b1;
        bus.req_addr  = 64'h200;
        @(negedge clk);
        start = cyc;
        tick();
        bus.req_valid = 1'b0;
        wait_rsp_valid(20, ok);
        n_tests++;
        if (!ok || cyc - start != MEM_LAT + 1 || bus.rsp_pc !== 64'h200) begin
            n_fail++;
            $display("FAIL flush_next got ok=%b lat=%0d pc=%h exp ok=1 lat=%0d pc=200",
                     ok, cyc - start, bus.rsp_pc, MEM_LAT + 1);
        end
        repeat (2) tick();
    endtask

    task automatic test_misaligned();
        int base;
        bit ok;
        logic [63:0] addrs [3];
        addrs[0] = 64'h100;
        addrs[1] = 64'h102;
        addrs[2] = 64'h104;
        base = got.size();
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.req_addr = addrs[k];
            @(negedge clk);
            n_tests++;
            if (bus.mem_rd_en !== (k != 1)) begin
                n_fail++;
                $display("FAIL mis_rd_en_%0d got=%b exp=%b", k, bus.mem_rd_en, (k != 1));
            end
            tick();
        end
        bus.req_valid = 1'b0;
        wait_got(base + 3, 20, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL mis_drain got %0d responses exp 3", got.size() - base);
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (got[base+k].pc !== addrs[k] || got[base+k].err !== (k == 1)
                    || got[base+k].instr !== ((k == 1) ? 32'h0 : mem_word(addrs[k]))) begin
                    n_fail++;
                    $display("FAIL mis_rsp_%0d got pc=%h instr=%h err=%b exp pc=%h err=%b",
                             k, got[base+k].pc, got[base+k].instr, got[base+k].err, addrs[k], (k == 1));
                end
            end
        end
        repeat (2) tick();
    endtask

    task automatic test_reset_mid();
        int base;
        base = got.size();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.req_addr = 64'h400 + 64'(i * 4);
            tick();
        end
        bus.req_valid = 1'b0;
        tick();
        // Two entries queued, the third still in flight.
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_during got rsp_valid=%b exp=0", bus.rsp_valid);
        end
        tick();
        rst           = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_stale_%0d got rsp_valid=%b pc=%h exp=0", i, bus.rsp_valid, bus.rsp_pc);
            end
            tick();
        end
        n_tests++;
        if (got.size() != base) begin
            n_fail++;
            $display("FAIL rstmid_no_rsp got %0d responses exp 0", got.size() - base);
        end
    endtask

    task automatic test_stream();
        int base;
        bit ok;
        base = got.size();
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.req_addr = rand_addr(1'b1);
            @(negedge clk);
            n_tests++;
            if (bus.req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_ready_%0d got=%b exp=1", i, bus.req_ready);
            end
            if (i >= MEM_LAT + 1) begin
                n_tests++;
                if (bus.rsp_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stream_rsp_%0d got rsp_valid=%b exp=1", i, bus.rsp_valid);
                end
            end
            tick();
        end
        bus.req_valid = 1'b0;
        wait_got(base + 40, 20, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL stream_count got=%0d exp=40", got.size() - base);
        end
        repeat (2) tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 299) == 0);
            bus.req_valid = ($urandom_range(0, 3) != 0);
            bus.req_addr  = rand_addr($urandom_range(0, 7) != 0);
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 39) == 0);
            tick();
        end
        rst           = 1'b0;
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (DEPTH + MEM_LAT + 4) tick();
        @(negedge clk);
        n_tests++;
        if (bus.rsp_valid !== 1'b0 || q.size() != 0) begin
            n_fail++;
            $display("FAIL random_drain got rsp_valid=%b model_left=%0d exp 0 0", bus.rsp_valid, q.size());
        end
        tick();
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = 64'h0;
        bus.flush     = 1'b0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_back_pressure();
        test_flush();
        test_misaligned();
        test_reset_mid();
        test_stream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
